// File: rtl/mem_param.sv
`default_nettype none
// ============================================================================
//  Module   : mem_param
//  Purpose  : Parametrised single-port synchronous RAM with a registered
//             read-valid strobe, write-first collisions, out-of-range
//             rejection and a hardware clear sequencer that zeroes the
//             array after reset or on request.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 11
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              clr_req,
    output logic [DATA_W-1:0] Data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam logic [0:0]        c_ST_IDLE   = 1'b0;
    localparam logic [0:0]        c_ST_CLEAR  = 1'b1;
    localparam logic [ADDR_W-1:0] c_PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              r_err;
    logic              r_busy;

    logic              w_idle;
    logic              w_in_range;
    logic              w_do_wr;
    logic              w_do_rd;
    logic              w_reject;
    logic [DATA_W-1:0] w_rd_data;

    assign w_idle     = (r_state == c_ST_IDLE);
    // Extend by one bit so DEPTH == 2**ADDR_W compares correctly.
    assign w_in_range = ({1'b0, addr} < c_DEPTH_EXT);
    assign w_do_wr    = w_idle & wr & w_in_range;
    assign w_do_rd    = w_idle & rd & w_in_range;
    // Any access while clearing or outside the array is flagged.
    assign w_reject   = (wr | rd) & (~w_idle | ~w_in_range);
    // Single port: a simultaneous write targets the read address, so the
    // incoming data wins (write-first).
    assign w_rd_data  = wr ? Data_in : r_mem[addr];

    // State and clear pointer; reset restarts the clear from entry 0.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic for the clear sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            c_ST_CLEAR: begin
                if (r_ptr == c_PTR_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + ADDR_W'(1);
                end
            end
            default: begin
                if (clr_req) begin
                    w_state_nxt = c_ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
        endcase
    end

    // Array write port: clear zeroes one entry per cycle, otherwise user writes.
    always_ff @(posedge Clk) begin
        if (rst_n) begin
            if (r_state == c_ST_CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else if (w_do_wr) begin
                r_mem[addr] <= Data_in;
            end
        end
    end

    // Registered outputs: read data, valid strobe, error pulse and busy flag.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_valid <= w_do_rd;
            r_err   <= w_reject;
            r_busy  <= (w_state_nxt == c_ST_CLEAR);
            if (w_do_rd) begin
                r_dout <= w_rd_data;
            end
        end
    end

    assign Data_out = r_dout;
    assign rd_valid = r_valid;
    assign err      = r_err;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_param
//  Purpose  : Self-checking bench for mem_param: behavioural memory model
//             compared every cycle, directed scenarios with literal
//             expectations, randomized traffic and a wide/deep instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_param;

    localparam int c_DW = 8;
    localparam int c_AW = 4;
    localparam int c_DEPTH = 11;

    logic            Clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr = 1'b0;
    logic            rd = 1'b0;
    logic [c_AW-1:0] addr = '0;
    logic [c_DW-1:0] Data_in = '0;
    logic            clr_req = 1'b0;
    logic [c_DW-1:0] Data_out;
    logic            rd_valid;
    logic            busy;
    logic            err;

    logic            wr2 = 1'b0;
    logic            rd2 = 1'b0;
    logic [5:0]      addr2 = '0;
    logic [15:0]     din2 = '0;
    logic [15:0]     dout2;
    logic            valid2;
    logic            busy2;
    logic            err2;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_param #(.DATA_W(c_DW), .ADDR_W(c_AW), .DEPTH(c_DEPTH)) u_dut (
        .Clk(Clk), .rst_n(rst_n), .wr(wr), .rd(rd), .addr(addr),
        .Data_in(Data_in), .clr_req(clr_req), .Data_out(Data_out),
        .rd_valid(rd_valid), .busy(busy), .err(err)
    );

    mem_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) u_dut_wide (
        .Clk(Clk), .rst_n(rst_n), .wr(wr2), .rd(rd2), .addr(addr2),
        .Data_in(din2), .clr_req(1'b0), .Data_out(dout2),
        .rd_valid(valid2), .busy(busy2), .err(err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a plain array plus a count of remaining clear
    // cycles. Clearing zeroes the whole array at once; accesses during the
    // clear are rejected, so the gradual zeroing is not observable.
    // ------------------------------------------------------------------
    logic [c_DW-1:0] m_mem [c_DEPTH];
    int              m_left;
    logic [c_DW-1:0] e_dout;
    logic            e_valid, e_err, e_busy;

    always begin
        @(posedge Clk or negedge rst_n);
        if (!rst_n) begin
            m_left  = c_DEPTH;
            e_dout  = '0;
            e_valid = 1'b0;
            e_err   = 1'b0;
            for (int i = 0; i < c_DEPTH; i++) m_mem[i] = '0;
        end else begin
            e_valid = 1'b0;
            e_err   = 1'b0;
            if (m_left > 0) begin
                e_err  = wr | rd;
                m_left = m_left - 1;
            end else begin
                if ((wr || rd) && int'(addr) >= c_DEPTH) begin
                    e_err = 1'b1;
                end else begin
                    if (wr) m_mem[addr] = Data_in;
                    if (rd) begin
                        e_dout  = m_mem[addr];
                        e_valid = 1'b1;
                    end
                end
                if (clr_req) begin
                    m_left = c_DEPTH;
                    for (int i = 0; i < c_DEPTH; i++) m_mem[i] = '0;
                end
            end
        end
        e_busy = (m_left > 0);
        #1;
        check("model_dout",  32'(Data_out), 32'(e_dout));
        check("model_valid", 32'(rd_valid), 32'(e_valid));
        check("model_err",   32'(err),      32'(e_err));
        check("model_busy",  32'(busy),     32'(e_busy));
    end

    task automatic drive(input logic w, input logic r, input int a, input int d, input logic c);
        @(negedge Clk);
        wr      = w;
        rd      = r;
        addr    = c_AW'(a);
        Data_in = c_DW'(d);
        clr_req = c;
    endtask

    // Wait until the sampling point just after the edge that consumes the drive.
    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        do begin
            @(posedge Clk);
            #2;
            n++;
        end while (busy && n < 200);
    endtask

    task automatic busy2_len(output int n);
        n = 0;
        do begin
            @(posedge Clk);
            #2;
            n++;
        end while (busy2 && n < 400);
    endtask

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge Clk);
            #2;
            n++;
        end
        check("busy_timeout", 32'(busy), 32'(0));
    endtask

    initial begin
        int n1, n2;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_dout",  32'(Data_out), 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_err",   32'(err),      32'h0);
        check("rst_busy",  32'(busy),     32'h1);
        check("rst_busy2", 32'(busy2),    32'h1);
        rst_n = 1'b1;
        fork
            busy_len(n1);
            busy2_len(n2);
        join
        check("clear_len", 32'(n1), 32'd11);
        check("clear_len_wide", 32'(n2), 32'd64);

        // Freshly cleared array reads zero
        for (int a = 0; a < c_DEPTH; a++) begin
            drive(1'b0, 1'b1, a, 0, 1'b0);
            settle();
            check("clr_read_val", 32'(Data_out), 32'h0);
            check("clr_read_vld", 32'(rd_valid), 32'h1);
        end
        idle();
        settle();
        check("idle_vld", 32'(rd_valid), 32'h0);

        // Write then read, one-cycle latency
        drive(1'b1, 1'b0, 3, 'hA5, 1'b0);
        settle();
        check("wr_no_vld", 32'(rd_valid), 32'h0);
        drive(1'b0, 1'b1, 3, 0, 1'b0);
        settle();
        check("rd3_val", 32'(Data_out), 32'hA5);
        check("rd3_vld", 32'(rd_valid), 32'h1);

        // Write-first collision
        drive(1'b1, 1'b0, 5, 'h11, 1'b0);
        drive(1'b1, 1'b1, 5, 'h3C, 1'b0);
        settle();
        check("coll_val", 32'(Data_out), 32'h3C);
        check("coll_vld", 32'(rd_valid), 32'h1);
        drive(1'b0, 1'b1, 5, 0, 1'b0);
        settle();
        check("coll_reread", 32'(Data_out), 32'h3C);

        // Out-of-range accesses
        drive(1'b1, 1'b0, 12, 'hFF, 1'b0);
        settle();
        check("oor_wr_err", 32'(err), 32'h1);
        drive(1'b0, 1'b1, 12, 0, 1'b0);
        settle();
        check("oor_rd_err",  32'(err),      32'h1);
        check("oor_rd_vld",  32'(rd_valid), 32'h0);
        check("oor_rd_dout", 32'(Data_out), 32'h3C);
        idle();
        settle();
        check("oor_err_once", 32'(err), 32'h0);

        // Requested clear with a read in the same cycle
        for (int a = 0; a < c_DEPTH; a++) drive(1'b1, 1'b0, a, a + 1, 1'b0);
        drive(1'b0, 1'b1, 7, 0, 1'b1);
        settle();
        check("clr_rd_preval", 32'(Data_out), 32'h08);
        check("clr_busy", 32'(busy), 32'h1);
        drive(1'b0, 1'b1, 7, 0, 1'b0);
        settle();
        check("busy_rd_err", 32'(err),      32'h1);
        check("busy_rd_vld", 32'(rd_valid), 32'h0);
        idle();
        wait_not_busy();
        drive(1'b0, 1'b1, 7, 0, 1'b0);
        settle();
        check("after_clr_7", 32'(Data_out), 32'h0);

        // Reset in the middle of a clear
        for (int a = 0; a < c_DEPTH; a++) drive(1'b1, 1'b0, a, 'h50 + a, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 1'b1);
        repeat (4) idle();
        @(negedge Clk);
        rst_n = 1'b0;
        #1;
        check("midrst_dout", 32'(Data_out), 32'h0);
        check("midrst_busy", 32'(busy),     32'h1);
        check("midrst_vld",  32'(rd_valid), 32'h0);
        repeat (2) @(negedge Clk);
        rst_n = 1'b1;
        busy_len(n1);
        check("midrst_clear_len", 32'(n1), 32'd11);
        for (int a = 0; a < c_DEPTH; a++) drive(1'b0, 1'b1, a, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 63) == 0));
        end
        idle();
        wait_not_busy();

        // Wide/deep instance: top entry is addressable and not an error
        @(negedge Clk);
        wr2 = 1'b1; addr2 = 6'd63; din2 = 16'hBEEF;
        @(negedge Clk);
        wr2 = 1'b0; rd2 = 1'b1;
        #1;
        check("wide_wr_err", 32'(err2), 32'h0);
        settle();
        check("wide_rd_val", 32'(dout2),  32'hBEEF);
        check("wide_rd_vld", 32'(valid2), 32'h1);
        check("wide_rd_err", 32'(err2),   32'h0);
        @(negedge Clk);
        rd2 = 1'b1; addr2 = 6'd0;
        settle();
        check("wide_rd0", 32'(dout2), 32'h0);
        @(negedge Clk);
        rd2 = 1'b0;

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
